// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings
// reused by every bit-serial unit so their debug views line up.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_nx;
   logic             last_bit;

   full_subtractor u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (br),
      .d   (d_bit),
      .bout(br_nx)
   );

   // The counter stops at WIDTH-1; that cycle retires the final bit.
   assign last_bit  = (cnt == CW'(WIDTH - 1));
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nx = ST_RUN;
         ST_RUN:  if (last_bit)  state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default:                state_nx = ST_IDLE;
      endcase
   end

   // Datapath: operands are captured on acceptance so the upstream side may
   // move on; each RUN cycle shifts one difference bit into diff's MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh <= a;
                  b_sh <= b;
                  br   <= bin;
                  cnt  <= '0;
                  diff <= '0;
               end
            end
            ST_RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= br_nx;
               diff <= {d_bit, diff[WIDTH-1:1]};
               if (last_bit) begin
                  bout <= br_nx;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): table vectors, directed
// stall/reset sequences and random operations checked through a scoreboard.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] diff;
      logic       bout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       bin;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] diff;
   logic       bout;

   int         nCompared = 0;
   int         nMismatched = 0;
   logic [4:0] sb[$];
   vec_t       vecs[10];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .bout     (bout)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one operand set, waits for acceptance and records the expectation.
   task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb,
                                input logic vbin, input logic [4:0] expv);
      int guard = 0;
      @(negedge clk);
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      sb.push_back(expv);
      @(negedge clk);
      in_valid = 1'b0;
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
   endtask

   // Called on the negedge right after acceptance: checks latency, the
   // result, optional stall hold behaviour and the return to IDLE.
   task automatic checkOutput(input int stall, input string tag, input bit jitter);
      int         lat = 0;
      logic [4:0] expv;
      logic [4:0] held;
      while (!out_valid && lat < 40) begin
         if (jitter) out_ready = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_valid_edge"}, 32'(lat + 1), 32'(WIDTH + 1));
      if (!out_valid) return;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      expv = sb.pop_front();
      check({tag, "_result"}, {27'd0, bout, diff}, {27'd0, expv});
      held = {bout, diff};
      out_ready = 1'b0;
      repeat (stall) begin
         @(posedge clk);
         @(negedge clk);
      end
      if (stall > 0) begin
         check({tag, "_stall_hold"}, {27'd0, bout, diff}, {27'd0, held});
         check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_stall_inrdy"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_idle_inrdy"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_idle_hold"}, {27'd0, bout, diff}, {27'd0, held});
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rbin;
      logic [4:0] expv;

      vecs[0] = '{4'd10, 4'd2,  1'b0, 4'd8,  1'b0};
      vecs[1] = '{4'd2,  4'd10, 1'b0, 4'd8,  1'b1};
      vecs[2] = '{4'd10, 4'd10, 1'b1, 4'd15, 1'b1};
      vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
      vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
      vecs[5] = '{4'd1,  4'd2,  1'b0, 4'd15, 1'b1};
      vecs[6] = '{4'd8,  4'd7,  1'b1, 4'd0,  1'b0};
      vecs[7] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1};
      vecs[8] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
      vecs[9] = '{4'd3,  4'd4,  1'b1, 4'd14, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_inrdy", {31'd0, in_ready}, 32'd1);
      check("reset_outvalid", {31'd0, out_valid}, 32'd0);
      check("reset_result", {27'd0, bout, diff}, 32'd0);
      rst = 1'b0;

      $display("[TB] table vectors");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bout, vecs[i].diff});
         checkOutput(0, $sformatf("vec%0d", i), 1'b0);
      end

      // Stalled result with a second operand pending; it must wait for IDLE.
      $display("[TB] stall with pending operand");
      applyStimulus(4'd10, 4'd2, 1'b0, 5'd8);
      a = 4'd7; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
      checkOutput(3, "stall", 1'b0);
      @(posedge clk);
      sb.push_back(5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput(0, "stall_next", 1'b0);

      // Reset two cycles into RUN aborts the operation.
      $display("[TB] reset during run");
      applyStimulus(4'd9, 4'd3, 1'b0, 5'd6);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      check("abort_inrdy", {31'd0, in_ready}, 32'd1);
      check("abort_outvalid", {31'd0, out_valid}, 32'd0);
      check("abort_diff", {28'd0, diff}, 32'd0);
      applyStimulus(4'd5, 4'd6, 1'b0, 5'b11111);
      checkOutput(0, "after_abort", 1'b0);

      $display("[TB] random operations");
      for (int i = 0; i < 1000; i++) begin
         ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
         expv = {1'b0, ra} - {1'b0, rb} - {4'd0, rbin};
         applyStimulus(ra, rb, rbin, expv);
         checkOutput(int'($urandom_range(0, 3)), "rnd", 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
